// File: rtl/data_memory_be.sv
// Byte-addressable MEM-stage data memory: sub-word loads/stores with byte enables,
// base-address decoding, alignment/range error detection and a wait-state handshake.
module data_memory_be #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int          WAIT_STATES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  Done,
  output logic                  AddrError
);
  localparam int          IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * MEMORY_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [1:0]  stateReg;
  logic [3:0]  cntReg;
  logic [31:0] addrReg;
  logic [31:0] dataReg;
  logic [1:0]  sizeReg;
  logic        unsReg;
  logic        writeReg;
  logic        errReg;

  logic        request;
  logic        illegal;
  logic        misaligned;
  logic        outOfRange;
  logic [31:0] liveOffset;

  assign request    = MemRead | MemWrite;
  assign liveOffset = Address - BASE_ADDR;
  assign outOfRange = (Address < BASE_ADDR) || (liveOffset >= SPAN);
  assign misaligned = ((Size == SZ_HALF) && Address[0]) ||
                      ((Size == 2'b10) && (Address[1:0] != 2'b00));
  assign illegal    = (MemRead & MemWrite) | (Size == 2'b11) | misaligned | outOfRange;

  // With zero wait states the access happens on the request edge, so the live
  // inputs are used; otherwise the values latched in IDLE drive the access.
  logic        useLive;
  logic [31:0] accAddr;
  logic [31:0] accData;
  logic [1:0]  accSize;
  logic        accUns;
  logic        accWrite;
  logic [31:0] accOffset;
  logic [IDX_W-1:0] accIdx;
  logic [1:0]  accLane;
  logic        doAccess;
  logic        doWrite;

  assign useLive   = (stateReg == S_IDLE);
  assign accAddr   = useLive ? Address   : addrReg;
  assign accData   = useLive ? WriteData : dataReg;
  assign accSize   = useLive ? Size      : sizeReg;
  assign accUns    = useLive ? Unsigned  : unsReg;
  assign accWrite  = useLive ? MemWrite  : writeReg;
  assign accOffset = accAddr - BASE_ADDR;
  assign accIdx    = accOffset[IDX_W+1:2];
  assign accLane   = accAddr[1:0];

  assign doAccess = ((stateReg == S_IDLE) && request && !illegal && (WAIT_STATES == 0)) ||
                    ((stateReg == S_WAIT) && (cntReg == 4'd0));
  assign doWrite  = doAccess & accWrite;

  logic [3:0]  laneEn;
  logic [31:0] wdRep;

  always_comb begin
    laneEn = 4'b1111;
    wdRep  = accData;
    case (accSize)
      SZ_BYTE: begin
        laneEn = 4'b0001 << accLane;
        wdRep  = {4{accData[7:0]}};
      end
      SZ_HALF: begin
        laneEn = 4'b0011 << accLane;
        wdRep  = {2{accData[15:0]}};
      end
      default: ;
    endcase
  end

  logic [7:0] rdLane [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      logic [7:0] ram [MEMORY_DEPTH];

      always_ff @(posedge clk) begin
        if (doWrite && laneEn[gi]) begin
          ram[accIdx] <= wdRep[8*gi +: 8];
        end
      end

      assign rdLane[gi] = ram[accIdx];
    end
  endgenerate

  logic [31:0] rdWord;
  logic [31:0] shifted;
  logic [31:0] loadVal;

  assign rdWord  = {rdLane[3], rdLane[2], rdLane[1], rdLane[0]};
  assign shifted = rdWord >> {accLane, 3'b000};

  always_comb begin
    loadVal = rdWord;
    case (accSize)
      SZ_BYTE: loadVal = accUns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: loadVal = accUns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  logic unusedBits;
  assign unusedBits = ^{accOffset[31:IDX_W+2], accOffset[1:0], shifted[31:16]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= S_IDLE;
      cntReg   <= 4'd0;
      ReadData <= '0;
      errReg   <= 1'b0;
      addrReg  <= '0;
      dataReg  <= '0;
      sizeReg  <= '0;
      unsReg   <= 1'b0;
      writeReg <= 1'b0;
    end else begin
      case (stateReg)
        S_IDLE: begin
          if (request) begin
            addrReg  <= Address;
            dataReg  <= WriteData;
            sizeReg  <= Size;
            unsReg   <= Unsigned;
            writeReg <= MemWrite;
            errReg   <= illegal;
            if (illegal) begin
              stateReg <= S_DONE;
              ReadData <= '0;
            end else if (WAIT_STATES == 0) begin
              stateReg <= S_DONE;
              if (!MemWrite) ReadData <= loadVal;
            end else begin
              stateReg <= S_WAIT;
              cntReg   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cntReg == 4'd0) begin
            stateReg <= S_DONE;
            if (!writeReg) ReadData <= loadVal;
          end else begin
            cntReg <= cntReg - 4'd1;
          end
        end
        default: stateReg <= S_IDLE;
      endcase
    end
  end

  assign Stall     = ((stateReg == S_IDLE) && request) || (stateReg == S_WAIT);
  assign Done      = (stateReg == S_DONE);
  assign AddrError = (stateReg == S_DONE) && errReg;
endmodule

// File: doc/data_memory_be.md
Name: data_memory_be

Overview:
- Byte-addressable data memory for the MIPS MEM stage.
- Successor to the single-cycle word RAM; adds:
  - byte/halfword/word stores with byte enables
  - signed/unsigned sub-word loads
  - base-address decoding
  - alignment/range error detection
  - a parametrised wait-state handshake that stalls the pipeline until the access completes

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32 (four byte lanes).
- MEMORY_DEPTH, 256, number of 32-bit words.
- BASE_ADDR, 32'h1001_0000, byte address of word 0.
- WAIT_STATES, 2, extra cycles per legal access (0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- Address  input  32  byte address.
- WriteData  input  32  store data; sub-word data right-justified.
- MemWrite  input  1  store request.
- MemRead  input  1  load request.
- Size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- Unsigned  input  1  1 = zero-extend sub-word loads; 0 = sign-extend.
- ReadData  output  32  registered load result.
- Stall  output  1  combinational; high while the request is not yet complete.
- Done  output  1  one-cycle completion pulse.
- AddrError  output  1  one-cycle error pulse, coincident with Done.

Behaviour:

Reset and storage
- Reset (async): state=IDLE, wait counter=0, ReadData=0, Done=0, AddrError=0.
- RAM array is not reset; contents survive reset.

Requests and state machine
- Request = MemRead | MemWrite. Sampled only in IDLE.
- States: IDLE, WAIT, DONE.
- IDLE, request at rising edge:
  - Latch Address, WriteData, Size, Unsigned, and op.
  - If illegal: go to DONE with an error flag set.
  - Else if WAIT_STATES==0: perform the access at this edge and go to DONE.
  - Else: go to WAIT with counter=WAIT_STATES-1.
- WAIT: counter decrements each edge. At the edge where counter==0, perform the access and go to DONE.
- DONE (exactly one cycle): Done=1; AddrError=1 if an error was flagged; requests are ignored; next state IDLE.

Latency
- Legal access: Done is high in cycle N+WAIT_STATES+1, where N is the request cycle.
- Illegal access: Done is high in cycle N+1, regardless of WAIT_STATES.

Stall and requester rule
- Stall = (IDLE & request) | WAIT. Stall is low in DONE.
- Requester holds all inputs stable while Stall=1 and deasserts its request in the DONE cycle.

Illegal conditions (any one makes the access illegal)
- MemRead & MemWrite both high.
- Size==11.
- Halfword with Address[0]=1.
- Word with Address[1:0]!=0.
- Address<BASE_ADDR or Address>=BASE_ADDR+4*MEMORY_DEPTH.
- Effect: no RAM change; ReadData=0 in DONE.

Decoding
- Word index = (Address-BASE_ADDR)>>2, using index bits clog2(MEMORY_DEPTH).
- Byte offset = Address[1:0].
- Little-endian: offset 0 = bits 7:0.

Stores
- Byte: writes lane offset only, with WriteData[7:0].
- Halfword: writes lanes offset and offset+1, with WriteData[15:0].
- Word: writes all four lanes.
- Unselected lanes keep their old value.

Loads
- The selected byte/halfword is shifted to bit 0, then extended per Unsigned.
- Result is registered into ReadData at the access edge, so it is valid in the DONE cycle.
- ReadData holds its value until the next completed load or error. A completed store leaves ReadData unchanged.

Reset mid-operation
- A pending store is discarded; RAM is untouched because the write edge is never reached.
- State returns to IDLE.

Test Plan:
1. WAIT_STATES=2; store word 0xDEADBEEF at 0x10010004, then load word from 0x10010004.
   - Required: Stall high cycles 0-2; Done high cycle 3; ReadData=0xDEADBEEF in the load's DONE cycle.
2. After (1), store byte 0x12 at 0x10010005, then load word.
   - Required: ReadData=0xDEAD12EF.
3. Mem = 0x80FF7F01 at 0x10010008. Loads:
   - byte signed @+0 -> 0x00000001
   - byte signed @+3 -> 0xFFFFFF80
   - half unsigned @+2 -> 0x000080FF
   - half signed @+2 -> 0xFFFF80FF
4. Illegal requests:
   - load word at 0x10010006 -> AddrError=1 with Done in cycle 1; ReadData=0.
   - store at 0x0FFFFFFC -> AddrError=1; memory dump unchanged.
   - Size=11 -> AddrError=1.
5. Issue a store word at 0x10010010; assert reset during WAIT.
   - Required: Done=0, Stall=0 (once the request is dropped), ReadData=0 immediately after reset; a later load of 0x10010010 returns the pre-store value.
6. WAIT_STATES=0; back-to-back loads.
   - Required: Done every second cycle; requests presented during DONE are ignored; Stall low in DONE.
